wb_stage_seq: RTL
=================

Name: wb_stage_seq

Overview:
- Registered, parametrised write-back stage between the MEM stage/data cache and the register file.
- Accepts one retiring instruction per handshake and selects its result: ALU, formatted load data, or link address.
- Formats loads as byte, half, word or XLEN, signed or unsigned, with big-endian lane order.
- Waits for late cache data with a timeout, flags misaligned and timed-out loads, and latches halt after the halting instruction retires.

Parameters:
XLEN, 32, datapath width; 32 or 64.
NB, XLEN/8, byte lanes in cache_data_out (derived, not overridable).
LINK_OFFSET, 4, added to inst_addr for register_src=2'b10.
MEM_TIMEOUT, 16, max cycles spent in WAIT_MEM; must be ≥1.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  upstream holds a retiring instruction.
in_ready  out  1  stage can accept; combinational, 1 only in IDLE.
register_src  in  2  00 ALU, 01 load, 10 link, 11 ALU.
load_size  in  2  00 byte, 01 half, 10 32-bit word, 11 XLEN.
load_unsigned  in  1  zero-extend when 1, sign-extend when 0.
byte_number  in  $clog2(NB)  byte offset of the load within the line.
reg_write_in  in  1  instruction writes rd.
rd_num_in  in  5  destination register.
inst_addr  in  XLEN  PC of the instruction.
ALU_result  in  XLEN  ALU output.
cache_data_out  in  XLEN  lane i = bits[8i+7:8i]; byte offset k maps to lane NB-1-k.
cache_valid  in  1  cache_data_out valid this cycle.
halted_controller  in  1  instruction is a halt.
rf_we  out  1  one-cycle register-file write strobe.
rd_num_out  out  5  registered destination.
rd_data  out  XLEN  registered write data.
last_stage_halted  out  1  sticky halt.
misalign_err  out  1  one-cycle pulse.
timeout_err  out  1  one-cycle pulse.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, timeout counter=0.
  - rf_we, rd_num_out, rd_data, last_stage_halted, misalign_err and timeout_err all 0.
  - Reset during WAIT_MEM discards the pending load; no write occurs.
- States: IDLE, WAIT_MEM, HALTED.
- Acceptance:
  - An instruction is accepted when in_valid && in_ready at a clock edge.
  - Accepted fields are latched.
  - rf_we, rd_data and rd_num_out default low/hold; rf_we and the error outputs are strobes cleared each cycle unless re-asserted.
- IDLE, non-load accept: at the accepting edge register rd_data and rd_num_out, and set rf_we = reg_write_in && rd_num_in≠0. Latency is 1 cycle.
- IDLE, load accept with cache_valid=1: format and write at the same edge, latency 1.
- IDLE, load accept with cache_valid=0: go to WAIT_MEM and clear the counter.
- WAIT_MEM:
  - in_ready=0; the counter increments each cycle.
  - On cache_valid: format the latched request against the current cache_data_out, write, and return to IDLE.
  - If the counter reaches MEM_TIMEOUT-1 with cache_valid=0: pulse timeout_err, return to IDLE, no write.
  - cache_valid in that same cycle wins over the timeout.
- Load formatting, with offset k = byte_number:
  - byte: lane NB-1-k.
  - half: {lane NB-1-k, lane NB-2-k}.
  - word: four lanes starting at lane NB-1-k, MSB first.
  - XLEN: all lanes, MSB = lane NB-1.
  - Extension follows load_unsigned. A 32-bit word in XLEN=32 and the XLEN size are unextended.
- Alignment:
  - k must be a multiple of the access size in bytes.
  - load_size=11 with XLEN=32 is treated as a word.
  - A misaligned load pulses misalign_err at its write edge, rf_we=0, and does not wait for cache_valid.
- Link: rd_data = inst_addr + LINK_OFFSET, modulo 2^XLEN (wrap-around).
- rd_num_in=0: rd_data still updates but rf_we=0.
- Halt: when the accepted instruction has halted_controller=1, its own write and its errors complete normally. At that same completing edge last_stage_halted ←1 and state→HALTED.
- HALTED: in_ready=0, no further writes. Only reset exits HALTED.

Test Plan:
- ALU path: accept ALU_result=0x1234_5678, rd=5, reg_write=1 → next edge rf_we=1, rd_num_out=5, rd_data=0x1234_5678; rf_we=0 the cycle after.
- Byte load, XLEN=32: cache_data_out=0x80FF_7F01, cache_valid=1.
  - k=0, signed → 0xFFFF_FF80.
  - k=2, unsigned → 0x0000_007F.
  - k=3, signed → 0x0000_0001.
- Half and alignment: same data, half at k=2, unsigned → 0x0000_7F01. Half at k=1 → misalign_err pulse, rf_we=0, in_ready high next cycle.
- Late data and timeout:
  - Load with cache_valid low for 3 cycles then high with 0xDEAD_BEEF → in_ready=0 for 3 cycles, single write of 0xDEAD_BEEF.
  - With MEM_TIMEOUT=4 and cache_valid never high → timeout_err after 4 WAIT_MEM cycles, no rf_we.
- Link, wrap-around and rd=0: inst_addr=0xFFFF_FFFC, register_src=10 → rd_data=0x0000_0000. The same with rd=0 → rf_we=0.
- Halt and reset: halt instruction with ALU_result=7, rd=2 → rf_we with 7, then last_stage_halted=1 and in_ready=0 held. Assert rst_n=0 mid-cycle → all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/wb_stage_seq.sv
// Write-back stage: selects ALU, formatted load or link result for the register file,
// waits (bounded) for late cache data, reports misaligned/timed-out loads, latches halt.
module wb_stage_seq #(
    parameter  int XLEN        = 32,
    parameter  int LINK_OFFSET = 4,
    parameter  int MEM_TIMEOUT = 16,
    localparam int NB          = XLEN / 8,
    localparam int KW          = $clog2(NB)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      register_src,
    input  logic [1:0]      load_size,
    input  logic            load_unsigned,
    input  logic [KW-1:0]   byte_number,
    input  logic            reg_write_in,
    input  logic [4:0]      rd_num_in,
    input  logic [XLEN-1:0] inst_addr,
    input  logic [XLEN-1:0] ALU_result,
    input  logic [XLEN-1:0] cache_data_out,
    input  logic            cache_valid,
    input  logic            halted_controller,
    output logic            rf_we,
    output logic [4:0]      rd_num_out,
    output logic [XLEN-1:0] rd_data,
    output logic            last_stage_halted,
    output logic            misalign_err,
    output logic            timeout_err
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MEM = 2'b01,
        HALTED   = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rd_num_q, rd_num_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic              halted_q, halted_d;
    logic              mis_q, mis_d;
    logic              to_q, to_d;

    // Load request held across WAIT_MEM
    logic [1:0]        req_size_q;
    logic              req_uns_q;
    logic [KW-1:0]     req_k_q;
    logic              req_we_q;
    logic [4:0]        req_rd_q;
    logic              req_halt_q;

    logic              latch_req;
    logic              done;
    logic              halt_src;

    function automatic int unsigned access_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return (XLEN == 64) ? 8 : 4;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [KW-1:0] k);
        return (32'(k) & (access_bytes(size) - 1)) != 0;
    endfunction

    // Shifting left by 8*k puts the lane for offset k at the top, so every size reads MSB-first.
    function automatic logic [XLEN-1:0] format_load(
        input logic [XLEN-1:0] data,
        input logic [1:0]      size,
        input logic            uns,
        input logic [KW-1:0]   k
    );
        logic [XLEN-1:0]    sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        sh = data << {k, 3'b000};
        b  = sh[XLEN-1 -: 8];
        h  = sh[XLEN-1 -: 16];
        w  = sh[XLEN-1 -: 32];
        case (size)
            2'b00:   return uns ? XLEN'(unsigned'(b)) : XLEN'(b);
            2'b01:   return uns ? XLEN'(unsigned'(h)) : XLEN'(h);
            2'b10:   return uns ? XLEN'(unsigned'(w)) : XLEN'(w);
            default: return sh;
        endcase
    endfunction

    assign in_ready = (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rf_we_d   = 1'b0;
        rd_num_d  = rd_num_q;
        rd_data_d = rd_data_q;
        halted_d  = halted_q;
        mis_d     = 1'b0;
        to_d      = 1'b0;
        latch_req = 1'b0;
        done      = 1'b0;
        halt_src  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    done     = 1'b1;
                    halt_src = halted_controller;
                    if (register_src == 2'b01) begin
                        if (is_misaligned(load_size, byte_number)) begin
                            mis_d = 1'b1;
                        end else if (cache_valid) begin
                            rd_data_d = format_load(cache_data_out, load_size, load_unsigned, byte_number);
                            rd_num_d  = rd_num_in;
                            rf_we_d   = reg_write_in && (rd_num_in != 5'd0);
                        end else begin
                            state_d   = WAIT_MEM;
                            cnt_d     = '0;
                            latch_req = 1'b1;
                            done      = 1'b0;
                        end
                    end else begin
                        rd_num_d  = rd_num_in;
                        rd_data_d = (register_src == 2'b10) ? inst_addr + XLEN'(LINK_OFFSET) : ALU_result;
                        rf_we_d   = reg_write_in && (rd_num_in != 5'd0);
                    end
                end
            end
            WAIT_MEM: begin
                halt_src = req_halt_q;
                // Data arriving on the last allowed cycle still wins over the timeout
                if (cache_valid) begin
                    rd_data_d = format_load(cache_data_out, req_size_q, req_uns_q, req_k_q);
                    rd_num_d  = req_rd_q;
                    rf_we_d   = req_we_q && (req_rd_q != 5'd0);
                    done      = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done && halt_src) begin
            halted_d = 1'b1;
            state_d  = HALTED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rf_we_q   <= 1'b0;
            rd_num_q  <= '0;
            rd_data_q <= '0;
            halted_q  <= 1'b0;
            mis_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rf_we_q   <= rf_we_d;
            rd_num_q  <= rd_num_d;
            rd_data_q <= rd_data_d;
            halted_q  <= halted_d;
            mis_q     <= mis_d;
            to_q      <= to_d;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_req) begin
            req_size_q <= load_size;
            req_uns_q  <= load_unsigned;
            req_k_q    <= byte_number;
            req_we_q   <= reg_write_in;
            req_rd_q   <= rd_num_in;
            req_halt_q <= halted_controller;
        end
    end

    assign rf_we             = rf_we_q;
    assign rd_num_out        = rd_num_q;
    assign rd_data           = rd_data_q;
    assign last_stage_halted = halted_q;
    assign misalign_err      = mis_q;
    assign timeout_err       = to_q;

endmodule
